// File: rtl/access_key_issuer_if.sv
// access_key_issuer_if: request, key and verdict handshake bundle between a requester/gate and the key issuer
//   req_valid/req_target/req_addr/req_ready : transfer request into the issuer
//   key_valid/key_ready/key_out/key_target/key_addr : key presented to the security gate
//   resp_valid/resp_ok : gate verdict
//   lockout/fail_count : issuer status
// master = requester/gate side, slave = issuer side.
interface access_key_issuer_if;
    logic        req_valid;
    logic        req_target;
    logic [9:0]  req_addr;
    logic        req_ready;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] key_out;
    logic        key_target;
    logic [9:0]  key_addr;
    logic        resp_valid;
    logic        resp_ok;
    logic        lockout;
    logic [3:0]  fail_count;

    modport master (
        output req_valid, req_target, req_addr, key_ready, resp_valid, resp_ok,
        input  req_ready, key_valid, key_out, key_target, key_addr, lockout, fail_count
    );
    modport slave (
        input  req_valid, req_target, req_addr, key_ready, resp_valid, resp_ok,
        output req_ready, key_valid, key_out, key_target, key_addr, lockout, fail_count
    );
endinterface

// File: rtl/access_key_issuer.sv
// access_key_issuer: issues LFSR-derived, target/address-bound access keys and locks out after repeated rejections
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : access_key_issuer_if.slave (request in, key out, verdict in, lockout/fail_count status)
// Optional macro RESP_TIMEOUT_EN: a missing verdict after RESP_TIMEOUT cycles in WAIT_RESP counts as a rejection.
module access_key_issuer #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCK_CYCLES  = 16,
    parameter int          RESP_TIMEOUT = 8
) (
    input logic               clk,
    input logic               rst_n,
    access_key_issuer_if.slave bus
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, LOCKED} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [LW-1:0] lock_cnt;
    logic [3:0]    fail_next;
    logic          verdict;
    logic          ok;

    assign lfsr_next     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign fail_next     = (bus.fail_count == 4'(MAX_FAIL)) ? bus.fail_count : bus.fail_count + 4'd1;
    assign bus.req_ready = (state == IDLE);

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          timed_out;
    assign timed_out = (to_cnt == TW'(RESP_TIMEOUT - 1));
    // A real verdict in the timeout cycle wins; a timeout alone is a rejection.
    assign verdict   = bus.resp_valid | timed_out;
    assign ok        = bus.resp_valid & bus.resp_ok;
`else
    logic [31:0] unused_resp_timeout;
    assign unused_resp_timeout = RESP_TIMEOUT;
    assign verdict = bus.resp_valid;
    assign ok      = bus.resp_ok;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            lfsr           <= SEED;
            lock_cnt       <= '0;
            bus.key_valid  <= 1'b0;
            bus.key_out    <= 16'h0000;
            bus.key_target <= 1'b0;
            bus.key_addr   <= 10'h000;
            bus.lockout    <= 1'b0;
            bus.fail_count <= 4'd0;
`ifdef RESP_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.key_out    <= lfsr_next ^ {6'b0, bus.req_addr} ^ (bus.req_target ? 16'hA5A5 : 16'h5A5A);
                    bus.key_target <= bus.req_target;
                    bus.key_addr   <= bus.req_addr;
                    bus.key_valid  <= 1'b1;
                    lfsr           <= lfsr_next;
                    state          <= ISSUE;
                end
                ISSUE: if (bus.key_ready) begin
                    bus.key_valid <= 1'b0;
                    state         <= WAIT_RESP;
`ifdef RESP_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                end
                WAIT_RESP: begin
                    if (verdict) begin
                        if (ok) begin
                            bus.fail_count <= 4'd0;
                            state          <= IDLE;
                        end else begin
                            bus.fail_count <= fail_next;
                            bus.lockout    <= (fail_next == 4'(MAX_FAIL));
                            lock_cnt       <= '0;
                            state          <= (fail_next == 4'(MAX_FAIL)) ? LOCKED : IDLE;
                        end
                    end
`ifdef RESP_TIMEOUT_EN
                    else to_cnt <= to_cnt + 1'b1;
`endif
                end
                LOCKED: if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                    bus.lockout    <= 1'b0;
                    bus.fail_count <= 4'd0;
                    state          <= IDLE;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_access_key_issuer.sv
// tb_access_key_issuer: directed self-checking bench for access_key_issuer
module tb_access_key_issuer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    access_key_issuer_if bus();

    access_key_issuer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req_valid = 0; bus.req_target = 0; bus.req_addr = '0;
        bus.key_ready = 0; bus.resp_valid = 0; bus.resp_ok = 0;
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
    endtask

    task automatic issue(input logic tgt, input logic [9:0] addr);
        bus.req_valid = 1; bus.req_target = tgt; bus.req_addr = addr;
        cyc();
        bus.req_valid = 0;
    endtask

    task automatic handshake();
        bus.key_ready = 1;
        cyc();
        bus.key_ready = 0;
    endtask

    task automatic respond(input logic ok);
        bus.resp_valid = 1; bus.resp_ok = ok;
        cyc();
        bus.resp_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.key_valid !== 1'b0 || bus.key_out !== 16'h0000 ||
            bus.key_target !== 1'b0 || bus.key_addr !== 10'h000 || bus.lockout !== 1'b0 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL reset: rdy=%b kv=%b key=%h tgt=%b addr=%h lock=%b fc=%0d required 1 0 0000 0 000 0 0",
                     bus.req_ready, bus.key_valid, bus.key_out, bus.key_target, bus.key_addr, bus.lockout, bus.fail_count);
        end
    endtask

    task automatic test_key_mem();
        do_reset();
        issue(1'b0, 10'h000);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.key_valid !== 1'b1 || bus.key_out !== 16'h0399 ||
            bus.key_target !== 1'b0 || bus.key_addr !== 10'h000) begin
            failures++;
            $display("FAIL key_mem: rdy=%b kv=%b key=%h tgt=%b addr=%h required 0 1 0399 0 000",
                     bus.req_ready, bus.key_valid, bus.key_out, bus.key_target, bus.key_addr);
        end
    endtask

    task automatic test_key_reg();
        do_reset();
        issue(1'b1, 10'h3FF);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_out !== 16'hFF99 || bus.key_target !== 1'b1 || bus.key_addr !== 10'h3FF) begin
            failures++;
            $display("FAIL key_reg: kv=%b key=%h tgt=%b addr=%h required 1 ff99 1 3ff",
                     bus.key_valid, bus.key_out, bus.key_target, bus.key_addr);
        end
    endtask

    task automatic test_issue_hold();
        do_reset();
        issue(1'b0, 10'h000);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (bus.key_valid !== 1'b1 || bus.key_out !== 16'h0399 || bus.key_addr !== 10'h000) begin
                failures++;
                $display("FAIL issue_hold[%0d]: kv=%b key=%h addr=%h required 1 0399 000", i, bus.key_valid, bus.key_out, bus.key_addr);
            end
        end
        // verdict in the key_ready cycle must be ignored
        bus.resp_valid = 1; bus.resp_ok = 0;
        handshake();
        bus.resp_valid = 0;
        checks++;
        if (bus.key_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL handshake: kv=%b rdy=%b fc=%0d required 0 0 0", bus.key_valid, bus.req_ready, bus.fail_count);
        end
        respond(1'b1);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL accept_resp: rdy=%b fc=%0d required 1 0", bus.req_ready, bus.fail_count);
        end
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            issue(1'b0, 10'(k));
            handshake();
            respond(1'b0);
            checks++;
            if (bus.fail_count !== 4'(k) || bus.lockout !== (k == 3) || bus.req_ready !== (k != 3)) begin
                failures++;
                $display("FAIL reject[%0d]: fc=%0d lock=%b rdy=%b required %0d %b %b",
                         k, bus.fail_count, bus.lockout, bus.req_ready, k, k == 3, k != 3);
            end
        end
        bus.req_valid = 1;
        n = 1;
        while (bus.lockout === 1'b1 && n < 40) begin
            checks++;
            if (bus.req_ready !== 1'b0 || bus.key_valid !== 1'b0) begin
                failures++;
                $display("FAIL locked_ready: rdy=%b kv=%b required 0 0", bus.req_ready, bus.key_valid);
            end
            cyc();
            if (bus.lockout === 1'b1) n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL lock_len: %0d cycles required 16", n);
        end
        checks++;
        if (bus.lockout !== 1'b0 || bus.fail_count !== 4'd0 || bus.req_ready !== 1'b1 || bus.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL unlock: lock=%b fc=%0d rdy=%b kv=%b required 0 0 1 0", bus.lockout, bus.fail_count, bus.req_ready, bus.key_valid);
        end
        bus.req_valid = 0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        issue(1'b0, 10'h055);
        handshake();
        respond(1'b0);
        issue(1'b1, 10'h12A);
        handshake();
        rst_n = 0;
        cyc();
        rst_n = 1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.key_valid !== 1'b0 || bus.key_out !== 16'h0000 || bus.key_target !== 1'b0 ||
            bus.key_addr !== 10'h000 || bus.lockout !== 1'b0 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_abort: rdy=%b kv=%b key=%h tgt=%b addr=%h lock=%b fc=%0d required 1 0 0000 0 000 0 0",
                     bus.req_ready, bus.key_valid, bus.key_out, bus.key_target, bus.key_addr, bus.lockout, bus.fail_count);
        end
        issue(1'b0, 10'h000);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_out !== 16'h0399) begin
            failures++;
            $display("FAIL reseed_key: kv=%b key=%h required 1 0399", bus.key_valid, bus.key_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        issue(1'b0, 10'h000);
        handshake();
`ifdef RESP_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.req_ready !== 1'b0 || bus.fail_count !== 4'd0) begin
                failures++;
                $display("FAIL timeout_wait[%0d]: rdy=%b fc=%0d required 0 0", i, bus.req_ready, bus.fail_count);
            end
            cyc();
        end
        cyc();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.fail_count !== 4'd1) begin
            failures++;
            $display("FAIL timeout_fire: rdy=%b fc=%0d required 1 1", bus.req_ready, bus.fail_count);
        end
        issue(1'b0, 10'h001);
        handshake();
        for (int i = 0; i < 7; i++) cyc();
        respond(1'b1);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL timeout_priority: rdy=%b fc=%0d required 1 0", bus.req_ready, bus.fail_count);
        end
`else
        begin
            int stuck = 0;
            for (int i = 0; i < 100; i++) begin
                cyc();
                if (bus.req_ready === 1'b0 && bus.fail_count === 4'd0) stuck++;
            end
            checks++;
            if (stuck !== 100) begin
                failures++;
                $display("FAIL no_timeout: waited %0d of 100 cycles", stuck);
            end
        end
        respond(1'b1);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.fail_count !== 4'd0) begin
            failures++;
            $display("FAIL late_resp: rdy=%b fc=%0d required 1 0", bus.req_ready, bus.fail_count);
        end
`endif
    endtask

    initial begin
        cyc();
        test_reset();
        test_key_mem();
        test_key_reg();
        test_issue_hold();
        test_lockout();
        test_reset_abort();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
